// File: rtl/priority_resolver.sv
// Interrupt request / in-service / priority core of an 8259-style PIC: IRR capture with masking,
// fully nested priority with optional rotation, and the two-pulse INTA grant sequence.
module priority_resolver #(
   parameter int NUM_IR = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_IR-1:0] ir,
   input  logic [NUM_IR-1:0] imr,
   input  logic              ltim,
   input  logic              aeoi,
   input  logic              auto_rotate,
   input  logic              inta,
   input  logic              eoi,
   output logic              int_out,
   output logic [NUM_IR-1:0] irr,
   output logic [NUM_IR-1:0] isr,
   output logic [NUM_IR-1:0] grant_onehot,
   output logic              grant_valid,
   output logic              spurious
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK1 = 1'b1
   } state_t;

   // Returns {found, index} of the highest-priority set bit; priority runs from low+1 (highest)
   // around to low (lowest). Scanning lowest-to-highest lets the last hit win.
   function automatic logic [3:0] pick_highest(input logic [NUM_IR-1:0] vec, input logic [2:0] low);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      for (int p = 7; p >= 0; p--) begin
         idx = low + 3'(p) + 3'd1;
         if (vec[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Rank 0 is the highest priority under the current rotation.
   function automatic logic [2:0] rank_of(input logic [2:0] idx, input logic [2:0] low);
      return idx - low - 3'd1;
   endfunction

   function automatic logic [2:0] onehot_to_idx(input logic [NUM_IR-1:0] vec);
      logic [2:0] res;
      res = 3'd0;
      for (int i = 0; i < NUM_IR; i++) begin
         if (vec[i]) res = 3'(i);
      end
      return res;
   endfunction

   state_t            state_q, state_d;
   logic [NUM_IR-1:0] ir_d_q;
   logic [NUM_IR-1:0] irr_q, irr_d;
   logic [NUM_IR-1:0] isr_q, isr_d;
   logic [NUM_IR-1:0] grant_onehot_q, grant_onehot_d;
   logic              grant_valid_q, grant_valid_d;
   logic              spurious_q, spurious_d;
   logic              int_out_q, int_out_d;
   logic [2:0]        lowest_q, lowest_d;
   logic              inta_q;

   logic              inta_rise;
   logic [NUM_IR-1:0] masked_req;
   logic [3:0]        cand_res, svc_res;
   logic              cand_found, svc_found;
   logic [2:0]        cand_idx, svc_idx, grant_idx;
   logic              cand_outranks;
   logic [NUM_IR-1:0] cand_onehot;
   logic [NUM_IR-1:0] irr_edge;
   logic [NUM_IR-1:0] irr_clr, isr_clr, isr_set;

   assign inta_rise     = inta & ~inta_q;
   assign masked_req    = irr_q & ~imr;
   assign cand_res      = pick_highest(masked_req, lowest_q);
   assign svc_res       = pick_highest(isr_q, lowest_q);
   assign cand_found    = cand_res[3];
   assign cand_idx      = cand_res[2:0];
   assign svc_found     = svc_res[3];
   assign svc_idx       = svc_res[2:0];
   assign cand_onehot   = NUM_IR'(1) << cand_idx;
   assign grant_idx     = onehot_to_idx(grant_onehot_q);
   assign cand_outranks = !svc_found || (rank_of(cand_idx, lowest_q) < rank_of(svc_idx, lowest_q));

   // Edge mode: a request latches on a rising ir edge and holds only while ir stays high.
   for (genvar gi = 0; gi < NUM_IR; gi++) begin : g_irr_edge
      assign irr_edge[gi] = ir[gi] & (irr_q[gi] | ~ir_d_q[gi]);
   end

   always_comb begin
      state_d        = state_q;
      grant_onehot_d = grant_onehot_q;
      grant_valid_d  = grant_valid_q;
      spurious_d     = spurious_q;
      lowest_d       = lowest_q;
      irr_clr        = '0;
      isr_clr        = '0;
      isr_set        = '0;

      case (state_q)
         IDLE: begin
            if (inta_rise) begin
               state_d = ACK1;
               if (cand_found) begin
                  grant_onehot_d = cand_onehot;
                  grant_valid_d  = 1'b1;
                  spurious_d     = 1'b0;
                  isr_set        = cand_onehot;
                  irr_clr        = cand_onehot;
               end else begin
                  grant_onehot_d = 8'h80;
                  grant_valid_d  = 1'b0;
                  spurious_d     = 1'b1;
               end
            end
         end
         ACK1: begin
            if (inta_rise) begin
               state_d       = IDLE;
               grant_valid_d = 1'b0;
               spurious_d    = 1'b0;
               if (aeoi && !spurious_q) begin
                  isr_clr = grant_onehot_q;
                  if (auto_rotate) lowest_d = grant_idx;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A non-specific EOI retires the highest in-service level; it works on the pre-cycle ISR.
      if (eoi && svc_found) begin
         isr_clr[svc_idx] = 1'b1;
         if (auto_rotate) lowest_d = svc_idx;
      end

      isr_d     = (isr_q & ~isr_clr) | isr_set;
      irr_d     = ltim ? ir : (irr_edge & ~irr_clr);
      int_out_d = (state_d == IDLE) && cand_found && cand_outranks;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         ir_d_q         <= '0;
         irr_q          <= '0;
         isr_q          <= '0;
         grant_onehot_q <= '0;
         grant_valid_q  <= 1'b0;
         spurious_q     <= 1'b0;
         int_out_q      <= 1'b0;
         lowest_q       <= 3'd7;
         inta_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         ir_d_q         <= ir;
         irr_q          <= irr_d;
         isr_q          <= isr_d;
         grant_onehot_q <= grant_onehot_d;
         grant_valid_q  <= grant_valid_d;
         spurious_q     <= spurious_d;
         int_out_q      <= int_out_d;
         lowest_q       <= lowest_d;
         inta_q         <= inta;
      end
   end

   assign int_out      = int_out_q;
   assign irr          = irr_q;
   assign isr          = isr_q;
   assign grant_onehot = grant_onehot_q;
   assign grant_valid  = grant_valid_q;
   assign spurious     = spurious_q;

endmodule
